// File: rtl/multilane_issue_queue.sv
// ---------------------------------------------------------------------------
// multilane_issue_queue
//
// Schedules instruction groups into NUM_LANES execution lanes on a shared,
// wrapping position timeline. Each accepted push becomes one FIFO entry
// {start, count, payload} in its lane. Every consumer advance replays, per
// lane, one member of the head group: member index rd_pos - start, for as
// long as rd_pos lies inside [start, start+count). Wrap-safe serial-number
// comparisons keep the position counters running forever without reset.
//
// Handshake: a push is transferred on a rising clk edge where
// in_valid && in_ready. in_ready is combinational from current state and
// the in_* inputs, and never depends on in_valid. A push with in_count == 0
// shows in_ready = 1 and changes nothing. out_ready is a pure advance
// request: the timeline moves by one position only when out_ready is high
// and at least one lane FIFO holds an entry.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   lane_latency       per-lane completion latency, LAT_BITS per lane
//   in_valid/in_ready  push handshake
//   in_lane            target lane of the push
//   in_count           group size (1..MAX_COPY)
//   in_payload         instruction word
//   out_ready          consumer advances one position
//   out_valid          per-lane valid (registered)
//   out_payload        per-lane payload (registered)
//   out_thread         per-lane member index within its group (registered)
//   empty              all lane FIFOs are empty (combinational)
// ---------------------------------------------------------------------------
module multilane_issue_queue #(
  parameter int NUM_LANES = 3,
  parameter int LANE_W    = 40,
  parameter int POS_BITS  = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_COPY  = 16,
  parameter int LAT_BITS  = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_LANES*LAT_BITS-1:0]          lane_latency,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [$clog2(NUM_LANES)-1:0]           in_lane,
  input  logic [$clog2(MAX_COPY):0]              in_count,
  input  logic [LANE_W-1:0]                      in_payload,
  input  logic                                   out_ready,
  output logic [NUM_LANES-1:0]                   out_valid,
  output logic [NUM_LANES*LANE_W-1:0]            out_payload,
  output logic [NUM_LANES*$clog2(MAX_COPY)-1:0]  out_thread,
  output logic                                   empty
);

  localparam int LW = $clog2(NUM_LANES);
  localparam int CW = $clog2(MAX_COPY) + 1;
  localparam int TW = $clog2(MAX_COPY);
  localparam int AW = $clog2(DEPTH);

  typedef logic [POS_BITS-1:0] pos_t;

  // a is strictly ahead of b when the wrapped distance is nonzero and
  // inside the lower half of the ring.
  function automatic logic pos_gt(input pos_t a, input pos_t b);
    pos_t d;
    d = a - b;
    return (d != '0) && !d[POS_BITS-1];
  endfunction

  function automatic pos_t pos_max(input pos_t a, input pos_t b);
    return pos_gt(a, b) ? a : b;
  endfunction

  // Timeline and scheduling state
  pos_t           rd_pos_q, rd_pos_d;
  logic [LW-1:0]  prev_lane_q, prev_lane_d;
  pos_t           next_free_q [NUM_LANES];
  pos_t           next_free_d [NUM_LANES];
  pos_t           done_q      [NUM_LANES];
  pos_t           done_d      [NUM_LANES];

  // Per-lane FIFO storage; pointers carry one extra wrap bit
  pos_t              start_mem [NUM_LANES][DEPTH];
  logic [CW-1:0]     count_mem [NUM_LANES][DEPTH];
  logic [LANE_W-1:0] pay_mem   [NUM_LANES][DEPTH];
  logic [AW:0]       wr_ptr_q  [NUM_LANES];
  logic [AW:0]       wr_ptr_d  [NUM_LANES];
  logic [AW:0]       rd_ptr_q  [NUM_LANES];
  logic [AW:0]       rd_ptr_d  [NUM_LANES];

  // Registered outputs
  logic [NUM_LANES-1:0]        out_valid_q;
  logic [NUM_LANES*LANE_W-1:0] out_payload_q;
  logic [NUM_LANES*TW-1:0]     out_thread_q;

  // Head-of-FIFO view per lane
  logic [NUM_LANES-1:0] fifo_empty;
  logic [NUM_LANES-1:0] fifo_full;
  logic [NUM_LANES-1:0] hit;
  logic [NUM_LANES-1:0] last;
  pos_t                 head_start [NUM_LANES];
  logic [CW-1:0]        head_count [NUM_LANES];
  logic [LANE_W-1:0]    head_pay   [NUM_LANES];
  pos_t                 offset     [NUM_LANES];

  // Push-side combinational signals
  logic          lane_ok;
  logic [LW-1:0] lane_sel;
  pos_t          ins_pos;
  pos_t          count_pos;
  pos_t          span;
  logic          push;
  logic          advance;
  logic [AW-1:0] wr_idx;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      fifo_empty[l] = (wr_ptr_q[l] == rd_ptr_q[l]);
      fifo_full[l]  = (wr_ptr_q[l][AW] != rd_ptr_q[l][AW]) &&
                      (wr_ptr_q[l][AW-1:0] == rd_ptr_q[l][AW-1:0]);
      head_start[l] = start_mem[l][rd_ptr_q[l][AW-1:0]];
      head_count[l] = count_mem[l][rd_ptr_q[l][AW-1:0]];
      head_pay[l]   = pay_mem[l][rd_ptr_q[l][AW-1:0]];
      // Before the group starts the offset wraps to a large value, so a
      // single unsigned compare covers both ends of the interval.
      offset[l]     = rd_pos_q - head_start[l];
      hit[l]        = !fifo_empty[l] && (offset[l] < pos_t'(head_count[l]));
      last[l]       = hit[l] && (offset[l] == pos_t'(head_count[l]) - pos_t'(1));
    end
  end

  assign empty   = &fifo_empty;
  assign advance = out_ready && !empty;

  assign lane_ok   = (32'(in_lane) < 32'(NUM_LANES));
  assign lane_sel  = lane_ok ? in_lane : '0;
  assign count_pos = pos_t'(in_count);
  // Earliest slot: after the previous group's completion, after this lane's
  // last scheduled member, and strictly after the position being read now
  // (so a push concurrent with an advance never lands on a consumed slot).
  assign ins_pos   = pos_max(pos_max(done_q[prev_lane_q], next_free_q[lane_sel]),
                             rd_pos_q + pos_t'(1));
  // Group end must stay within the half-ring window ahead of rd_pos.
  assign span      = ins_pos + count_pos - rd_pos_q;
  assign in_ready  = (in_count == '0) ? 1'b1
                   : (lane_ok && !fifo_full[lane_sel] && !span[POS_BITS-1]);
  assign push      = in_valid && in_ready && (in_count != '0);
  assign wr_idx    = wr_ptr_q[lane_sel][AW-1:0];

  always_comb begin
    rd_pos_d    = rd_pos_q;
    prev_lane_d = prev_lane_q;
    if (advance) rd_pos_d = rd_pos_q + pos_t'(1);
    if (push)    prev_lane_d = lane_sel;
    for (int l = 0; l < NUM_LANES; l++) begin
      next_free_d[l] = next_free_q[l];
      done_d[l]      = done_q[l];
      wr_ptr_d[l]    = wr_ptr_q[l];
      rd_ptr_d[l]    = rd_ptr_q[l];
      // Drag values that rd_pos is about to pass, so an idle lane's marks
      // never fall far enough behind to alias as "ahead" after a wrap.
      if (advance && next_free_q[l] == rd_pos_q) next_free_d[l] = rd_pos_q + pos_t'(1);
      if (advance && done_q[l] == rd_pos_q)      done_d[l]      = rd_pos_q + pos_t'(1);
      if (advance && last[l])                    rd_ptr_d[l]    = rd_ptr_q[l] + 1'b1;
      if (push && lane_sel == LW'(l)) begin
        next_free_d[l] = ins_pos + count_pos;
        done_d[l]      = ins_pos + pos_t'(lane_latency[l*LAT_BITS +: LAT_BITS]);
        wr_ptr_d[l]    = wr_ptr_q[l] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pos_q    <= '0;
      prev_lane_q <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        next_free_q[l] <= '0;
        done_q[l]      <= '0;
        wr_ptr_q[l]    <= '0;
        rd_ptr_q[l]    <= '0;
      end
    end else begin
      rd_pos_q    <= rd_pos_d;
      prev_lane_q <= prev_lane_d;
      for (int l = 0; l < NUM_LANES; l++) begin
        next_free_q[l] <= next_free_d[l];
        done_q[l]      <= done_d[l];
        wr_ptr_q[l]    <= wr_ptr_d[l];
        rd_ptr_q[l]    <= rd_ptr_d[l];
      end
    end
  end

  // Storage needs no reset: an entry is only read once its pointer says so.
  always_ff @(posedge clk) begin
    if (push) begin
      start_mem[lane_sel][wr_idx] <= ins_pos;
      count_mem[lane_sel][wr_idx] <= in_count;
      pay_mem[lane_sel][wr_idx]   <= in_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= '0;
      out_payload_q <= '0;
      out_thread_q  <= '0;
    end else if (advance) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        out_valid_q[l] <= hit[l];
        if (hit[l]) begin
          out_payload_q[l*LANE_W +: LANE_W] <= head_pay[l];
          out_thread_q[l*TW +: TW]          <= offset[l][TW-1:0];
        end
      end
    end else if (out_ready) begin
      // Advance requested with nothing queued.
      out_valid_q <= '0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_payload = out_payload_q;
  assign out_thread  = out_thread_q;

endmodule

// File: tb/tb_multilane_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_multilane_issue_queue
//
// Directed bench for multilane_issue_queue. Instance dut_a uses DEPTH=4 and
// covers ordering, wrap, FIFO-full, concurrent push/advance and reset.
// Instance dut_b uses DEPTH=8 so the scheduling window, not FIFO depth, is
// the limiting factor. Lane latencies are {10,3,4} for lanes 2,1,0.
// ---------------------------------------------------------------------------
module tb_multilane_issue_queue;

  localparam logic [39:0] PAY0 = 40'h00_1111_0000;
  localparam logic [39:0] PAY1 = 40'h00_2222_0001;
  localparam logic [39:0] PAY2 = 40'h00_3333_0002;

  logic clk;
  logic reset;
  logic [11:0] lane_latency;

  logic         in_valid_a, in_ready_a, out_ready_a, empty_a;
  logic [1:0]   in_lane_a;
  logic [4:0]   in_count_a;
  logic [39:0]  in_payload_a;
  logic [2:0]   out_valid_a;
  logic [119:0] out_payload_a;
  logic [11:0]  out_thread_a;

  logic         in_valid_b, in_ready_b, out_ready_b, empty_b;
  logic [1:0]   in_lane_b;
  logic [4:0]   in_count_b;
  logic [39:0]  in_payload_b;
  logic [2:0]   out_valid_b;
  logic [119:0] out_payload_b;
  logic [11:0]  out_thread_b;

  int vectors;
  int miscompares;
  logic [39:0] exp_pay [3];

  multilane_issue_queue #(
    .NUM_LANES(3), .LANE_W(40), .POS_BITS(8), .DEPTH(4), .MAX_COPY(16), .LAT_BITS(4)
  ) dut_a (
    .clk(clk), .reset(reset), .lane_latency(lane_latency),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_lane(in_lane_a),
    .in_count(in_count_a), .in_payload(in_payload_a), .out_ready(out_ready_a),
    .out_valid(out_valid_a), .out_payload(out_payload_a), .out_thread(out_thread_a),
    .empty(empty_a)
  );

  multilane_issue_queue #(
    .NUM_LANES(3), .LANE_W(40), .POS_BITS(8), .DEPTH(8), .MAX_COPY(16), .LAT_BITS(4)
  ) dut_b (
    .clk(clk), .reset(reset), .lane_latency(lane_latency),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_lane(in_lane_b),
    .in_count(in_count_b), .in_payload(in_payload_b), .out_ready(out_ready_b),
    .out_valid(out_valid_b), .out_payload(out_payload_b), .out_thread(out_thread_b),
    .empty(empty_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid_a = 1'b0; out_ready_a = 1'b0; in_lane_a = '0; in_count_a = '0; in_payload_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; in_lane_b = '0; in_count_b = '0; in_payload_b = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Driver tasks (dut_a)
  task automatic push_a(input int lane, input int cnt, input logic [39:0] pay,
                        input logic exp_rdy, input string tag);
    in_lane_a = 2'(lane); in_count_a = 5'(cnt); in_payload_a = pay; in_valid_a = 1'b1;
    #1;
    vectors++;
    if (in_ready_a !== exp_rdy) begin
      miscompares++;
      $display("FAIL %s in_ready: got %b required %b", tag, in_ready_a, exp_rdy);
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
  endtask

  task automatic beat_a(input logic [2:0] ev, input int t0, input int t1, input int t2,
                        input string tag);
    int t [3];
    t[0] = t0; t[1] = t1; t[2] = t2;
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    vectors++;
    if (out_valid_a !== ev) begin
      miscompares++;
      $display("FAIL %s out_valid: got %b required %b", tag, out_valid_a, ev);
    end
    for (int l = 0; l < 3; l++) begin
      if (ev[l]) begin
        vectors++;
        if (out_thread_a[l*4 +: 4] !== 4'(t[l])) begin
          miscompares++;
          $display("FAIL %s lane%0d thread: got %0d required %0d", tag, l,
                   out_thread_a[l*4 +: 4], t[l]);
        end
        vectors++;
        if (out_payload_a[l*40 +: 40] !== exp_pay[l]) begin
          miscompares++;
          $display("FAIL %s lane%0d payload: got %h required %h", tag, l,
                   out_payload_a[l*40 +: 40], exp_pay[l]);
        end
      end
    end
  endtask

  task automatic drain_a(input int exp_beats, input string tag);
    int beats;
    beats = 0;
    out_ready_a = 1'b1;
    #1;
    while (empty_a !== 1'b1 && beats < 100) begin
      @(posedge clk); #1;
      beats++;
    end
    out_ready_a = 1'b0;
    vectors++;
    if (beats != exp_beats) begin
      miscompares++;
      $display("FAIL %s drain beats: got %0d required %0d", tag, beats, exp_beats);
    end
  endtask

  task automatic check_empty_a(input logic exp, input string tag);
    vectors++;
    if (empty_a !== exp) begin
      miscompares++;
      $display("FAIL %s empty: got %b required %b", tag, empty_a, exp);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid_a !== 3'b000) begin
      miscompares++; $display("FAIL rst out_valid: got %b required 000", out_valid_a);
    end
    vectors++;
    if (out_payload_a !== '0) begin
      miscompares++; $display("FAIL rst out_payload: got %h required 0", out_payload_a);
    end
    vectors++;
    if (out_thread_a !== '0) begin
      miscompares++; $display("FAIL rst out_thread: got %h required 0", out_thread_a);
    end
    check_empty_a(1'b1, "rst");
    vectors++;
    if (empty_b !== 1'b1) begin
      miscompares++; $display("FAIL rst empty_b: got %b required 1", empty_b);
    end
    // A zero-count push is accepted but leaves the queue untouched.
    push_a(1, 0, PAY1, 1'b1, "rst_cnt0");
    check_empty_a(1'b1, "rst_cnt0");
  endtask

  task automatic test_basic_order();
    do_reset();
    push_a(1, 2, PAY1, 1'b1, "basic_push1"); exp_pay[1] = PAY1;
    push_a(0, 1, PAY0, 1'b1, "basic_push0"); exp_pay[0] = PAY0;
    check_empty_a(1'b0, "basic_loaded");
    beat_a(3'b000, 0, 0, 0, "basic_pos0");
    beat_a(3'b010, 0, 0, 0, "basic_pos1");
    beat_a(3'b010, 0, 1, 0, "basic_pos2");
    beat_a(3'b000, 0, 0, 0, "basic_pos3");
    beat_a(3'b001, 0, 0, 0, "basic_pos4");
    check_empty_a(1'b1, "basic_done");
    beat_a(3'b000, 0, 0, 0, "basic_empty_adv");
  endtask

  task automatic test_wrap();
    do_reset();
    exp_pay[0] = PAY0;
    for (int r = 0; r < 14; r++) begin
      push_a(0, 16, PAY0, 1'b1, "wrap_fill");
      drain_a(17, "wrap_fill");
    end
    push_a(0, 14, PAY0, 1'b1, "wrap_last");
    drain_a(15, "wrap_last");
    // rd_pos is now 253; the group lands at 254 and straddles the wrap.
    push_a(2, 4, PAY2, 1'b1, "wrap_push"); exp_pay[2] = PAY2;
    beat_a(3'b000, 0, 0, 0, "wrap_pos253");
    beat_a(3'b100, 0, 0, 0, "wrap_pos254");
    beat_a(3'b100, 0, 0, 1, "wrap_pos255");
    beat_a(3'b100, 0, 0, 2, "wrap_pos0");
    beat_a(3'b100, 0, 0, 3, "wrap_pos1");
    check_empty_a(1'b1, "wrap_done");
  endtask

  task automatic test_fifo_full();
    logic [2:0] ev;
    do_reset();
    exp_pay[2] = PAY2; exp_pay[0] = PAY0;
    for (int k = 0; k < 4; k++) push_a(2, 1, PAY2, 1'b1, "full_fill");
    in_lane_a = 2'd2; in_count_a = 5'd1; in_payload_a = PAY2; in_valid_a = 1'b1;
    #1;
    vectors++;
    if (in_ready_a !== 1'b0) begin
      miscompares++; $display("FAIL full_lane2 in_ready: got %b required 0", in_ready_a);
    end
    in_lane_a = 2'd0; in_payload_a = PAY0;
    #1;
    vectors++;
    if (in_ready_a !== 1'b1) begin
      miscompares++; $display("FAIL full_lane0 in_ready: got %b required 1", in_ready_a);
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    // lane2 at 1,11,21,31 (latency 10 chaining), lane0 at 41
    for (int p = 0; p <= 41; p++) begin
      ev = 3'b000;
      if (p == 1 || p == 11 || p == 21 || p == 31) ev = 3'b100;
      if (p == 41) ev = 3'b001;
      beat_a(ev, 0, 0, 0, "full_drain");
    end
    check_empty_a(1'b1, "full_done");
  endtask

  task automatic test_window();
    do_reset();
    in_lane_b = 2'd2; in_count_b = 5'd16; in_payload_b = PAY2;
    for (int k = 0; k < 8; k++) begin
      in_valid_b = 1'b1;
      #1;
      vectors++;
      if (in_ready_b !== (k < 7)) begin
        miscompares++;
        $display("FAIL win_push%0d in_ready: got %b required %b", k, in_ready_b, (k < 7));
      end
      @(posedge clk); #1;
      in_valid_b = 1'b0;
    end
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
    vectors++;
    if (out_valid_b !== 3'b000) begin
      miscompares++; $display("FAIL win_pop1 out_valid: got %b required 000", out_valid_b);
    end
    in_valid_b = 1'b1;
    #1;
    vectors++;
    if (in_ready_b !== 1'b0) begin
      miscompares++; $display("FAIL win_pop1 in_ready: got %b required 0", in_ready_b);
    end
    in_valid_b = 1'b0;
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
    vectors++;
    if (out_valid_b !== 3'b100 || out_thread_b[11:8] !== 4'd0) begin
      miscompares++;
      $display("FAIL win_pop2 lane2: got valid %b thread %0d required 100 thread 0",
               out_valid_b, out_thread_b[11:8]);
    end
    in_valid_b = 1'b1;
    #1;
    vectors++;
    if (in_ready_b !== 1'b1) begin
      miscompares++; $display("FAIL win_pop2 in_ready: got %b required 1", in_ready_b);
    end
    in_valid_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_pay[0] = PAY0; exp_pay[1] = PAY1;
    push_a(0, 4, PAY0, 1'b1, "b2b_fill");
    drain_a(5, "b2b_fill");
    // rd_pos = 5, queue empty, push with out_ready held high.
    out_ready_a = 1'b1;
    push_a(1, 1, PAY1, 1'b1, "b2b_push");
    out_ready_a = 1'b0;
    vectors++;
    if (out_valid_a !== 3'b000) begin
      miscompares++; $display("FAIL b2b_push out_valid: got %b required 000", out_valid_a);
    end
    beat_a(3'b000, 0, 0, 0, "b2b_pos5");
    beat_a(3'b010, 0, 0, 0, "b2b_pos6");
    check_empty_a(1'b1, "b2b_done");
  endtask

  task automatic test_reset_mid_group();
    do_reset();
    exp_pay[0] = PAY0; exp_pay[1] = PAY1;
    push_a(0, 8, PAY0, 1'b1, "rmid_push");
    beat_a(3'b000, 0, 0, 0, "rmid_pos0");
    beat_a(3'b001, 0, 0, 0, "rmid_pos1");
    beat_a(3'b001, 1, 0, 0, "rmid_pos2");
    beat_a(3'b001, 2, 0, 0, "rmid_pos3");
    beat_a(3'b001, 3, 0, 0, "rmid_pos4");
    reset = 1'b1; out_ready_a = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (out_valid_a !== 3'b000) begin
      miscompares++; $display("FAIL rmid_after out_valid: got %b required 000", out_valid_a);
    end
    check_empty_a(1'b1, "rmid_after");
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    vectors++;
    if (out_valid_a !== 3'b000) begin
      miscompares++; $display("FAIL rmid_tail out_valid: got %b required 000", out_valid_a);
    end
    push_a(1, 1, PAY1, 1'b1, "rmid_repush");
    beat_a(3'b000, 0, 0, 0, "rmid_re_pos0");
    beat_a(3'b010, 0, 0, 0, "rmid_re_pos1");
    check_empty_a(1'b1, "rmid_done");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    lane_latency = {4'd10, 4'd3, 4'd4};
    exp_pay[0] = '0; exp_pay[1] = '0; exp_pay[2] = '0;
    test_reset();
    test_basic_order();
    test_wrap();
    test_fifo_full();
    test_window();
    test_back_to_back();
    test_reset_mid_group();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multilane_issue_queue.md
Name: multilane_issue_queue

Overview:
Parametrised successor to the 3-lane superscalar instruction queue. It schedules instruction groups into NUM_LANES execution lanes on a shared modular position timeline, and replays one group member per lane per pop beat. Wrap-safe serial-number arithmetic replaces the external reset-on-overflow scheme. Push count is variable, per-lane latency is configurable, and push uses a valid/ready handshake. It sits between the decoder and the per-lane address-reconstruction / execution stages.

Parameters:
NUM_LANES, 3, number of execution lanes (at least 2)
LANE_W, 40, payload bits per instruction
POS_BITS, 8, width of the position counters; the scheduling window is 2^(POS_BITS-1)-1
DEPTH, 8, group entries per lane FIFO (power of 2)
MAX_COPY, 16, maximum group size (copies per push)
LAT_BITS, 4, width of each per-lane latency field

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
lane_latency  in  NUM_LANES*LAT_BITS  per-lane completion latency; quasi-static, lane i occupies bits [i*LAT_BITS +: LAT_BITS]
in_valid  in  1  push request
in_ready  out  1  push accepted when in_valid && in_ready
in_lane  in  $clog2(NUM_LANES)  target lane
in_count  in  $clog2(MAX_COPY)+1  group size, 1..MAX_COPY
in_payload  in  LANE_W  instruction word
out_ready  in  1  consumer advances one position
out_valid  out  NUM_LANES  per-lane instruction valid
out_payload  out  NUM_LANES*LANE_W  per-lane payload
out_thread  out  NUM_LANES*$clog2(MAX_COPY)  member index within the group
empty  out  1  all lane FIFOs empty

Behaviour:
- State:
  - rd_pos (POS_BITS)
  - prev_lane
  - per lane: next_free[l], done[l]
  - per lane: FIFO of {start, count, payload}
- Compare rule: gt(a,b) is true when (a-b) mod 2^POS_BITS is nonzero and below 2^(POS_BITS-1). All position sums wrap mod 2^POS_BITS.
- Insert position P = wrap-max(done[prev_lane], next_free[in_lane], rd_pos+1), computed combinationally from current-cycle state.
- in_ready (combinational) = lane FIFO for in_lane not full AND (P + in_count - rd_pos) mod 2^POS_BITS <= 2^(POS_BITS-1)-1.
- On accept:
  - enqueue {P, in_count, in_payload} into lane FIFO
  - next_free[in_lane] <= P + in_count
  - done[in_lane] <= P + lane_latency[in_lane]
  - prev_lane <= in_lane
- in_valid with in_count==0: in_ready=1 and no state change.
- Advance: when out_ready && !empty, rd_pos <= rd_pos+1. With out_ready && empty there is no advance and all out_valid are driven 0 next cycle.
- Output, registered, 1-cycle latency: on an advance, for each lane l with head entry H:
  - if rd_pos lies in [H.start, H.start+H.count) (wrap-aware):
    - out_valid[l] <= 1
    - out_payload[l] <= H.payload
    - out_thread[l] <= rd_pos - H.start
  - otherwise out_valid[l] <= 0 (bubble beat)
  - H is popped when rd_pos == H.start+H.count-1.
- Without an advance, outputs hold when out_ready=0 and clear valid when empty.
- empty is combinational: all FIFOs hold zero entries. A same-cycle push and advance read rd_pos before update; the pushed entry is visible from next cycle (P >= rd_pos+1 guarantees no missed slot).
- Reset:
  - rd_pos, next_free, done, FIFO pointers <= 0; prev_lane <= 0
  - out_valid, out_payload, out_thread <= 0; empty=1
  - Reset mid-group discards all groups; no partial output follows.
- Window guard: gt comparisons never see a distance of 2^(POS_BITS-1) or more. in_ready enforces this; the counters never need an external reset.

Test Plan:
1. lane_latency={10,3,4} (lanes 2,1,0), reset, then push lane1 cnt2 and lane0 cnt1 -> P=1 then P=4. Hold out_ready=1 -> beat0 all invalid; beats1,2 lane1 threads 0,1; beat3 bubble; beat4 lane0 thread0; empty=1 after.
2. Wrap: drive rd_pos to 253, push lane2 cnt4 -> P=254; pops -> lane2 threads 0..3 at rd_pos 254,255,0,1, FIFO popped at pos 1.
3. DEPTH=4: five lane2 pushes with no pops -> fifth sees in_ready=0; a lane0 push the same cycle is accepted.
4. Window: POS_BITS=8, chain lane2 cnt16 pushes without pops -> in_ready drops once P+16-rd_pos exceeds 127; one pop does not reopen it if still over.
5. Simultaneous push (lane1 cnt1) and advance at rd_pos=5 with an empty queue -> P=6, no lost slot, lane1 valid on the beat for pos 6.
6. Assert reset mid-group (lane0 cnt8, thread3 out) -> next cycle out_valid=0, empty=1, rd_pos=0; a push of cnt1 gives P=1.
